// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// Control-bit indices and default stage widths.
package pipe_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 4;
  localparam int CTRL_W_DEF    = 8;

  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_JUMP     = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_REGWRITE = 5;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: clear, saturating increment or hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready, flush,
// optional skid slot and stall counter.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int CTRL_W    = CTRL_W_DEF,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WORDS*DATA_W-1:0] in_words,
  input  logic [CTRL_W-1:0]           in_ctrl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*DATA_W-1:0] out_words,
  output logic [CTRL_W-1:0]           out_ctrl,
  input  logic                        flush,
  output logic [CNT_W-1:0]            stall_cnt,
  input  logic                        stall_clr
);

  localparam int WW = NUM_WORDS * DATA_W;

  logic              m_valid_q, m_valid_d;
  logic [WW-1:0]     m_words_q, m_words_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;

  logic              s_valid_q;
  logic [WW-1:0]     s_words_q;
  logic [CTRL_W-1:0] s_ctrl_q;

  logic in_fire;
  logic m_open;

  assign in_fire = in_valid & in_ready;
  // M can take a new beat when empty or draining
  assign m_open  = ~m_valid_q | out_ready;

  // main register: skid beat first, then input, else bubble
  always_comb begin
    m_valid_d = m_valid_q;
    m_words_d = m_words_q;
    m_ctrl_d  = m_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end else if (m_open) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_words_d = s_words_q;
        m_ctrl_d  = s_ctrl_q;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_words_d = in_words;
        m_ctrl_d  = in_ctrl;
      end else begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end
  end

  // main register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_words_q <= '0;
      m_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_words_q <= m_words_d;
      m_ctrl_q  <= m_ctrl_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic              s_valid_d;
    logic [WW-1:0]     s_words_d;
    logic [CTRL_W-1:0] s_ctrl_d;

    // skid slot fills when M is stuck, empties into M
    always_comb begin
      s_valid_d = s_valid_q;
      s_words_d = s_words_q;
      s_ctrl_d  = s_ctrl_q;
      if (flush) begin
        s_valid_d = 1'b0;
        s_ctrl_d  = '0;
      end else if (m_open) begin
        s_valid_d = s_valid_q & in_fire;
        if (s_valid_q & in_fire) begin
          s_words_d = in_words;
          s_ctrl_d  = in_ctrl;
        end
      end else if (in_fire) begin
        s_valid_d = 1'b1;
        s_words_d = in_words;
        s_ctrl_d  = in_ctrl;
      end
    end

    // skid slot state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_valid_q <= 1'b0;
        s_words_q <= '0;
        s_ctrl_q  <= '0;
      end else begin
        s_valid_q <= s_valid_d;
        s_words_q <= s_words_d;
        s_ctrl_q  <= s_ctrl_d;
      end
    end

    assign in_ready = ~s_valid_q;
  end else begin : g_noskid
    assign s_valid_q = 1'b0;
    assign s_words_q = '0;
    assign s_ctrl_q  = '0;
    assign in_ready  = out_ready | ~m_valid_q;
  end

  assign out_valid = m_valid_q;
  assign out_words = m_words_q;
  assign out_ctrl  = m_ctrl_q;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (m_valid_q & ~out_ready),
    .clr   (stall_clr),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer.
// Skid, no-skid and narrow-counter instances share stimulus.
module tb_pipe_stage_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_words = '0;
  logic [7:0]   in_ctrl = '0;
  logic         out_ready = 1'b1;
  logic         flush = 1'b0;
  logic         stall_clr = 1'b0;

  logic         v1, r1, v0, r0, v4, r4;
  logic [127:0] w1, w0, w4;
  logic [7:0]   c1, c0, c4;
  logic [15:0]  sc1, sc0;
  logic [3:0]   sc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
    .in_words(in_words), .in_ctrl(in_ctrl), .out_valid(v1),
    .out_ready(out_ready), .out_words(w1), .out_ctrl(c1),
    .flush(flush), .stall_cnt(sc1), .stall_clr(stall_clr));

  pipe_stage_buffer #(.SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0),
    .in_words(in_words), .in_ctrl(in_ctrl), .out_valid(v0),
    .out_ready(out_ready), .out_words(w0), .out_ctrl(c0),
    .flush(flush), .stall_cnt(sc0), .stall_clr(stall_clr));

  pipe_stage_buffer #(.SKID(1), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4),
    .in_words(in_words), .in_ctrl(in_ctrl), .out_valid(v4),
    .out_ready(out_ready), .out_words(w4), .out_ctrl(c4),
    .flush(flush), .stall_cnt(sc4), .stall_clr(stall_clr));

  function automatic logic [127:0] mkw(input int i);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = 32'(k * 16 + i);
    return w;
  endfunction

  task automatic drive(input logic v, input int i, input logic [7:0] c);
    in_valid = v;
    in_words = mkw(i);
    in_ctrl  = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    stall_clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (v1 !== 1'b0 || v0 !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b/%b exp 0", v1, v0);
    end
    checks++;
    if (w1 !== '0 || c1 !== 8'h00) begin
      errors++; $display("FAIL reset_data got %h/%h exp 0", w1, c1);
    end
    checks++;
    if (sc1 !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d exp 0", sc1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (r1 !== 1'b1 || r0 !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b/%b exp 1", r1, r0);
    end
  endtask

  task automatic test_stream();
    do_reset();
    drive(1'b1, 0, 8'h21);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (v1 !== 1'b1 || w1 !== mkw(i) || c1 !== 8'h21) begin
        errors++;
        $display("FAIL stream_s1[%0d] got %b %h %h exp 1 %h 21",
                 i, v1, w1, c1, mkw(i));
      end
      checks++;
      if (v0 !== 1'b1 || w0 !== mkw(i) || c0 !== 8'h21) begin
        errors++;
        $display("FAIL stream_s0[%0d] got %b %h %h exp 1 %h 21",
                 i, v0, w0, c0, mkw(i));
      end
      checks++;
      if (r1 !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, r1);
      end
      if (i < 7) drive(1'b1, i + 1, 8'h21);
      else in_valid = 1'b0;
    end
    checks++;
    if (sc1 !== 16'd0) begin
      errors++; $display("FAIL stream_cnt got %0d exp 0", sc1);
    end
  endtask

  task automatic test_skid_stall();
    do_reset();
    drive(1'b1, 10, 8'h21);
    @(negedge clk);
    checks++;
    if (w1 !== mkw(10) || v1 !== 1'b1) begin
      errors++; $display("FAIL skid_first got %h exp %h", w1, mkw(10));
    end
    drive(1'b1, 11, 8'h21);
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (r1 !== 1'b0) begin
      errors++; $display("FAIL skid_ready_fall got %b exp 0", r1);
    end
    drive(1'b1, 12, 8'h21);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sc1 !== 16'd3) begin
      errors++; $display("FAIL skid_cnt got %0d exp 3", sc1);
    end
    checks++;
    if (w1 !== mkw(10) || r1 !== 1'b0) begin
      errors++; $display("FAIL skid_hold got %h %b exp %h 0", w1, r1, mkw(10));
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (w1 !== mkw(11) || v1 !== 1'b1 || r1 !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain got %h %b %b exp %h 1 1", w1, v1, r1, mkw(11));
    end
    @(negedge clk);
    checks++;
    if (w1 !== mkw(12) || v1 !== 1'b1) begin
      errors++; $display("FAIL skid_next got %h exp %h", w1, mkw(12));
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (v1 !== 1'b0 || c1 !== 8'h00) begin
      errors++; $display("FAIL skid_empty got %b %h exp 0 00", v1, c1);
    end
  endtask

  task automatic test_noskid();
    do_reset();
    drive(1'b1, 20, 8'h21);
    @(negedge clk);
    drive(1'b1, 21, 8'h21);
    out_ready = 1'b0;
    #1;
    checks++;
    if (r0 !== 1'b0) begin
      errors++; $display("FAIL noskid_ready_low got %b exp 0", r0);
    end
    @(negedge clk);
    checks++;
    if (w0 !== mkw(20) || v0 !== 1'b1) begin
      errors++; $display("FAIL noskid_hold got %h exp %h", w0, mkw(20));
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (r0 !== 1'b1) begin
      errors++; $display("FAIL noskid_ready_high got %b exp 1", r0);
    end
    @(negedge clk);
    checks++;
    if (w0 !== mkw(21) || v0 !== 1'b1) begin
      errors++; $display("FAIL noskid_next got %h exp %h", w0, mkw(21));
    end
    checks++;
    if (sc0 !== 16'd1) begin
      errors++; $display("FAIL noskid_cnt got %0d exp 1", sc0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (v0 !== 1'b0) begin
      errors++; $display("FAIL noskid_empty got %b exp 0", v0);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 30, 8'h21);
    @(negedge clk);
    drive(1'b1, 31, 8'h21);
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (r1 !== 1'b0) begin
      errors++; $display("FAIL flush_sfull got %b exp 0", r1);
    end
    drive(1'b1, 32, 8'h21);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (v1 !== 1'b0 || c1 !== 8'h00 || r1 !== 1'b1) begin
      errors++;
      $display("FAIL flush_kill got %b %h %b exp 0 00 1", v1, c1, r1);
    end
    @(negedge clk);
    checks++;
    if (v1 !== 1'b0) begin
      errors++; $display("FAIL flush_noghost got %b exp 0", v1);
    end
    drive(1'b1, 33, 8'h21);
    @(negedge clk);
    checks++;
    if (w1 !== mkw(33) || v1 !== 1'b1 || c1 !== 8'h21) begin
      errors++; $display("FAIL flush_after got %h exp %h", w1, mkw(33));
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 40, 8'h21);
    @(negedge clk);
    drive(1'b1, 41, 8'h21);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sc1 !== 16'd1 || v1 !== 1'b1) begin
      errors++; $display("FAIL arst_pre got %0d %b exp 1 1", sc1, v1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (v1 !== 1'b0 || w1 !== '0 || c1 !== 8'h00 || sc1 !== 16'd0) begin
      errors++;
      $display("FAIL arst_now got %b %h %h %0d exp 0 0 0 0", v1, w1, c1, sc1);
    end
    drive(1'b1, 42, 8'h21);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 43, 8'h21);
    @(negedge clk);
    checks++;
    if (w1 !== mkw(43) || v1 !== 1'b1) begin
      errors++; $display("FAIL arst_first got %h exp %h", w1, mkw(43));
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (v1 !== 1'b0) begin
      errors++; $display("FAIL arst_noleft got %b exp 0", v1);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 50, 8'h21);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (sc4 !== 4'd15) begin
      errors++; $display("FAIL sat_cnt4 got %0d exp 15", sc4);
    end
    checks++;
    if (sc1 !== 16'd20) begin
      errors++; $display("FAIL sat_cnt16 got %0d exp 20", sc1);
    end
    stall_clr = 1'b1;
    @(negedge clk);
    stall_clr = 1'b0;
    checks++;
    if (sc4 !== 4'd0 || sc1 !== 16'd0) begin
      errors++; $display("FAIL sat_clr got %0d %0d exp 0 0", sc4, sc1);
    end
    @(negedge clk);
    checks++;
    if (sc4 !== 4'd1) begin
      errors++; $display("FAIL sat_resume got %0d exp 1", sc4);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_bubble();
    do_reset();
    drive(1'b1, 60, 8'h02);
    @(negedge clk);
    checks++;
    if (c1 !== 8'h02 || v1 !== 1'b1) begin
      errors++; $display("FAIL bubble_first got %h exp 02", c1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (c1 !== 8'h00 || v1 !== 1'b0) begin
      errors++; $display("FAIL bubble_1 got %b %h exp 0 00", v1, c1);
    end
    @(negedge clk);
    checks++;
    if (c1 !== 8'h00 || v1 !== 1'b0 || c0 !== 8'h00) begin
      errors++; $display("FAIL bubble_2 got %b %h %h exp 0 00 00", v1, c1, c0);
    end
    drive(1'b1, 61, 8'h02);
    @(negedge clk);
    checks++;
    if (c1 !== 8'h02 || w1 !== mkw(61)) begin
      errors++; $display("FAIL bubble_after got %h %h exp 02 %h", c1, w1, mkw(61));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_stall();
    test_noskid();
    test_flush();
    test_async_reset();
    test_saturate();
    test_bubble();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
